// File: rtl/axis_wrr_pkt_sched_4_if.sv
// AXI4-Stream bundle used for the scheduler's four source ports and its output port.
interface axis_wrr_pkt_sched_4_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_wrr_pkt_sched_4.sv
// Packet-granular 4:1 weighted round-robin AXI-S merge; 1 arbitration cycle per packet, beats pass through
// combinationally, backpressure goes straight to the granted source. AXIS_SCHED_TID_EN adds m_axis_tid.
module axis_wrr_pkt_sched_4 #(
  parameter int DATA_WIDTH   = 64,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_wrr_pkt_sched_4_if.slave   s00_axis,
  axis_wrr_pkt_sched_4_if.slave   s01_axis,
  axis_wrr_pkt_sched_4_if.slave   s02_axis,
  axis_wrr_pkt_sched_4_if.slave   s03_axis,
  axis_wrr_pkt_sched_4_if.master  m_axis,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight0,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight1,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight2,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight3,
`ifdef AXIS_SCHED_TID_EN
  output logic [1:0]              m_axis_tid,
`endif
  output logic                    busy,
  output logic [1:0]              grant_idx
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t                  state;
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [3:0]              req;
  logic [3:0]              last;
  logic [DATA_WIDTH-1:0]   dat [4];
  logic [WEIGHT_WIDTH-1:0] weight [4];
  logic [1:0]              win_idx;
  logic [1:0]              cand;
  logic [WEIGHT_WIDTH-1:0] win_weight;
  logic                    in_pkt;

  assign req  = {s03_axis.tvalid, s02_axis.tvalid, s01_axis.tvalid, s00_axis.tvalid};
  assign last = {s03_axis.tlast, s02_axis.tlast, s01_axis.tlast, s00_axis.tlast};

  assign dat[0] = s00_axis.tdata;
  assign dat[1] = s01_axis.tdata;
  assign dat[2] = s02_axis.tdata;
  assign dat[3] = s03_axis.tdata;

  assign weight[0] = cfg_weight0;
  assign weight[1] = cfg_weight1;
  assign weight[2] = cfg_weight2;
  assign weight[3] = cfg_weight3;

  // Scan from furthest to nearest so the port right after the last grant wins.
  always_comb begin
    win_idx = grant_idx;
    cand    = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = grant_idx + 2'(k);
      if (req[cand]) win_idx = cand;
    end
  end

  assign win_weight = weight[win_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= 2'd3;
      credit    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            if ((credit != '0) && req[grant_idx]) begin
              credit <= credit - WEIGHT_WIDTH'(1);
            end else begin
              // New turn: weight 0 behaves as 1, and leftover credit is dropped.
              grant_idx <= win_idx;
              credit    <= (win_weight == '0) ? '0 : win_weight - WEIGHT_WIDTH'(1);
            end
            state <= PKT;
          end
        end
        PKT: begin
          if (m_axis.tvalid && m_axis.tready && m_axis.tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_pkt = (state == PKT);
  assign busy   = in_pkt;

  assign m_axis.tvalid = in_pkt & req[grant_idx];
  assign m_axis.tlast  = in_pkt & last[grant_idx];
  assign m_axis.tdata  = in_pkt ? dat[grant_idx] : '0;

  assign s00_axis.tready = in_pkt && (grant_idx == 2'd0) && m_axis.tready;
  assign s01_axis.tready = in_pkt && (grant_idx == 2'd1) && m_axis.tready;
  assign s02_axis.tready = in_pkt && (grant_idx == 2'd2) && m_axis.tready;
  assign s03_axis.tready = in_pkt && (grant_idx == 2'd3) && m_axis.tready;

`ifdef AXIS_SCHED_TID_EN
  assign m_axis_tid = in_pkt ? grant_idx : 2'd0;
`endif

endmodule

// File: tb/tb_axis_wrr_pkt_sched_4.sv
// Directed bench for axis_wrr_pkt_sched_4: a packet/turn-level model checked every cycle plus literal order pins.
module tb_axis_wrr_pkt_sched_4;
  localparam int DW = 64;
  localparam int WW = 4;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_wrr_pkt_sched_4_if #(.DATA_WIDTH(DW)) s00_axis ();
  axis_wrr_pkt_sched_4_if #(.DATA_WIDTH(DW)) s01_axis ();
  axis_wrr_pkt_sched_4_if #(.DATA_WIDTH(DW)) s02_axis ();
  axis_wrr_pkt_sched_4_if #(.DATA_WIDTH(DW)) s03_axis ();
  axis_wrr_pkt_sched_4_if #(.DATA_WIDTH(DW)) m_axis ();

  logic [WW-1:0] cfg_weight [4];
  logic          busy;
  logic [1:0]    grant_idx;
`ifdef AXIS_SCHED_TID_EN
  logic [1:0]    m_axis_tid;
`endif

  logic          s_vld  [4];
  logic [DW-1:0] s_dat  [4];
  logic          s_last [4];
  logic          s_rdy  [4];
  logic          m_rdy;

  assign s00_axis.tvalid = s_vld[0];
  assign s01_axis.tvalid = s_vld[1];
  assign s02_axis.tvalid = s_vld[2];
  assign s03_axis.tvalid = s_vld[3];
  assign s00_axis.tdata  = s_dat[0];
  assign s01_axis.tdata  = s_dat[1];
  assign s02_axis.tdata  = s_dat[2];
  assign s03_axis.tdata  = s_dat[3];
  assign s00_axis.tlast  = s_last[0];
  assign s01_axis.tlast  = s_last[1];
  assign s02_axis.tlast  = s_last[2];
  assign s03_axis.tlast  = s_last[3];
  assign s_rdy[0] = s00_axis.tready;
  assign s_rdy[1] = s01_axis.tready;
  assign s_rdy[2] = s02_axis.tready;
  assign s_rdy[3] = s03_axis.tready;
  assign m_axis.tready = m_rdy;

  axis_wrr_pkt_sched_4 #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s00_axis    (s00_axis),
    .s01_axis    (s01_axis),
    .s02_axis    (s02_axis),
    .s03_axis    (s03_axis),
    .m_axis      (m_axis),
    .cfg_weight0 (cfg_weight[0]),
    .cfg_weight1 (cfg_weight[1]),
    .cfg_weight2 (cfg_weight[2]),
    .cfg_weight3 (cfg_weight[3]),
`ifdef AXIS_SCHED_TID_EN
    .m_axis_tid  (m_axis_tid),
`endif
    .busy        (busy),
    .grant_idx   (grant_idx)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    toggle_rdy = 1'b0;
  bit    fire [4];
  beat_t srcq [4][$];
  int    got_order [$];
  int    hs_cyc [$];
  int    exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Beat payload: port in [31:24], packet number in [23:16], beat number in [15:8].
  function automatic logic [DW-1:0] mk(input int p, input int pkt, input int b);
    return {32'h0, 8'(p), 8'(pkt), 8'(b), 8'hA5};
  endfunction

  task automatic push_pkt(input int p, input int pkt, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      beat_t bt;
      bt.dat  = mk(p, pkt, b);
      bt.last = (b == nbeats - 1);
      srcq[p].push_back(bt);
    end
  endtask

  // Source/sink driver: pops accepted beats and presents queue heads just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (fire[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
      if (srcq[p].size() > 0) begin
        s_vld[p]  = 1'b1;
        s_dat[p]  = srcq[p][0].dat;
        s_last[p] = srcq[p][0].last;
      end else begin
        s_vld[p]  = 1'b0;
        s_dat[p]  = '0;
        s_last[p] = 1'b0;
      end
    end
    m_rdy = toggle_rdy ? cyc[0] : 1'b1;
  end

  // Reference model: who owns the link, and how many more packets its turn may take.
  bit            m_busy;
  int            m_own;
  int            m_left;
  bit            stalled;
  logic [DW-1:0] held_dat;
  bit            out_in_pkt;
  int            cur_port;
  int            prev_beat;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0; m_own = 3; m_left = 0;
      stalled = 0; out_in_pkt = 0;
      for (int p = 0; p < 4; p++) fire[p] = 0;
    end else begin
      logic          exp_vld;
      logic          exp_last;
      logic [DW-1:0] exp_dat;
      logic [3:0]    exp_rdy;
      logic [3:0]    got_rdy;
      bit            found;
      exp_vld  = m_busy && s_vld[m_own];
      exp_last = m_busy && s_last[m_own];
      exp_dat  = m_busy ? s_dat[m_own] : '0;
      exp_rdy  = (m_busy && m_rdy) ? (4'b0001 << m_own) : 4'b0000;
      got_rdy  = {s_rdy[3], s_rdy[2], s_rdy[1], s_rdy[0]};
      check("m_tvalid", 64'(m_axis.tvalid), 64'(exp_vld));
      check("m_tdata", m_axis.tdata, exp_dat);
      check("m_tlast", 64'(m_axis.tlast), 64'(exp_last));
      check("s_tready", 64'(got_rdy), 64'(exp_rdy));
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_idx", 64'(grant_idx), 64'(m_own));
`ifdef AXIS_SCHED_TID_EN
      check("m_tid", 64'(m_axis_tid), m_busy ? 64'(m_own) : 64'd0);
`endif
      if (stalled) begin
        check("hold_vld", 64'(m_axis.tvalid), 64'd1);
        check("hold_dat", m_axis.tdata, held_dat);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        int port;
        int beat;
        port = int'(m_axis.tdata[31:24]);
        beat = int'(m_axis.tdata[15:8]);
        hs_cyc.push_back(cyc);
        if (out_in_pkt) check("no_interleave", 64'({port, beat}), 64'({cur_port, prev_beat + 1}));
        else check("sop_beat0", 64'(beat), 64'd0);
        cur_port = port;
        prev_beat = beat;
        out_in_pkt = !m_axis.tlast;
        if (m_axis.tlast) got_order.push_back(port);
      end
      stalled  = m_axis.tvalid && !m_axis.tready;
      held_dat = m_axis.tdata;
      for (int p = 0; p < 4; p++) fire[p] = s_vld[p] && s_rdy[p];

      if (m_busy) begin
        if (s_vld[m_own] && m_rdy && s_last[m_own]) m_busy = 0;
      end else if (s_vld[0] || s_vld[1] || s_vld[2] || s_vld[3]) begin
        if (m_left > 0 && s_vld[m_own]) begin
          m_left--;
        end else begin
          found = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && s_vld[(m_own + k) % 4]) begin
              m_own  = (m_own + k) % 4;
              m_left = ((cfg_weight[m_own] == 0) ? 1 : int'(cfg_weight[m_own])) - 1;
              found  = 1;
            end
          end
        end
        m_busy = 1;
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() > 0 || busy) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 64'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_order(input string name);
    check({name, "_count"}, 64'(got_order.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_order.size(); i++)
      check({name, "_port"}, 64'(got_order[i]), 64'(exp_q[i]));
  endtask

  task automatic start_test();
    got_order.delete();
    hs_cyc.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int p = 0; p < 4; p++) begin
      s_vld[p] = 1'b0; s_dat[p] = '0; s_last[p] = 1'b0; cfg_weight[p] = WW'(1);
    end
    m_rdy = 1'b1;

    // Reset values
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd3);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis.tlast), 64'd0);
    check("rst_tdata", m_axis.tdata, 64'd0);
    check("rst_tready", 64'({s_rdy[3], s_rdy[2], s_rdy[1], s_rdy[0]}), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // All ports, 1-beat packets, weight 1
    start_test();
    for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) push_pkt(p, r, 1);
    drain("t1", 200);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("t1_order");
    if (hs_cyc.size() == 8) check("t1_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'd14);
    else check("t1_beats", 64'(hs_cyc.size()), 64'd8);

    // Weight 3 on port 0, 2-beat packets
    start_test();
    cfg_weight[0] = WW'(3);
    for (int r = 0; r < 6; r++) push_pkt(0, r, 2);
    for (int p = 1; p < 4; p++) push_pkt(p, 0, 2);
    drain("t2", 300);
    exp_q = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    check_order("t2_order");

    // Port 2 alone, 5 beats, downstream ready toggling
    start_test();
    cfg_weight[0] = WW'(1);
    toggle_rdy = 1'b1;
    push_pkt(2, 0, 5);
    drain("t3", 200);
    toggle_rdy = 1'b0;
    exp_q = '{2};
    check_order("t3_order");
    check("t3_beats", 64'(hs_cyc.size()), 64'd5);

    // Port 1 weight 4 forfeits credit when it goes idle
    start_test();
    cfg_weight[1] = WW'(4);
    push_pkt(1, 0, 1);
    begin
      int n = 0;
      while (!busy && n < 50) begin @(posedge clk); #2; n++; end
      check("t4_wait_p1", 64'(n < 50), 64'd1);
    end
    push_pkt(3, 0, 3);
    begin
      int n = 0;
      while (!(busy && grant_idx == 2'd3) && n < 50) begin @(posedge clk); #2; n++; end
      check("t4_wait_p3", 64'(n < 50), 64'd1);
    end
    push_pkt(0, 0, 1);
    push_pkt(1, 1, 1);
    drain("t4", 200);
    exp_q = '{1, 3, 0, 1};
    check_order("t4_order");
    cfg_weight[1] = WW'(1);

    // Reset in the middle of a port 0 packet
    start_test();
    push_pkt(0, 0, 6);
    begin
      int n = 0;
      while (!(m_axis.tvalid && m_axis.tdata[15:8] == 8'd2) && n < 50) begin @(posedge clk); #2; n++; end
      check("t5_wait_beat3", 64'(n < 50), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    check("t5_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("t5_tready", 64'({s_rdy[3], s_rdy[2], s_rdy[1], s_rdy[0]}), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_grant", 64'(grant_idx), 64'd3);
    for (int p = 0; p < 4; p++) srcq[p].delete();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    start_test();
    for (int p = 3; p >= 0; p--) push_pkt(p, 1, 1);
    drain("t5", 200);
    exp_q = '{0, 1, 2, 3};
    check_order("t5_order");

    // Ports 1 and 3 backlogged
    start_test();
    for (int r = 0; r < 3; r++) begin
      push_pkt(1, r, 2);
      push_pkt(3, r, 2);
    end
    drain("t6", 300);
    exp_q = '{1, 3, 1, 3, 1, 3};
    check_order("t6_order");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
